umi_mem_device: RTL and testbench

- Local memory target that sits directly downstream of the UMI endpoint and consumes its loc_* interface.
- Holds DEPTH words of DW bits.
- Writes are byte-masked from the size, len and address offset.
- Read data returns exactly one cycle after an accepted read, LSB-aligned as UMI response data.
- Provides loc_ready backpressure so the endpoint's stall and response-hold paths can be exercised.

---
 rtl/umi_mem_device.sv | 102 ++++++++++
 tb/tb_umi_mem_device.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/umi_mem_device.sv
// umi_mem_device: local DEPTH x DW memory target behind the UMI endpoint loc_* interface.
// Writes are byte-masked from size/len/offset and clipped at the word end.
// Read data is registered and comes back one cycle after an accepted read.
// Optional feature: define UMI_MEM_STALL_EN to drop loc_ready one cycle in every STALL_PERIOD.
module umi_mem_device #(
    parameter int AW           = 64,
    parameter int DW           = 256,
    parameter int DEPTH        = 16,
    parameter int STALL_PERIOD = 4
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [AW-1:0] loc_addr,
    input  logic          loc_write,
    input  logic          loc_read,
    input  logic [7:0]    loc_opcode,
    input  logic [2:0]    loc_size,
    input  logic [7:0]    loc_len,
    input  logic [DW-1:0] loc_wrdata,
    output logic [DW-1:0] loc_rddata,
    output logic          loc_ready
);
    localparam int NB = DW / 8;
    localparam int OB = $clog2(NB);
    localparam int IW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [IW-1:0] index;
    logic [OB-1:0] offset;
    logic [15:0]   nbytes;
    logic [NB-1:0] wmask;
    logic [DW-1:0] wdata;
    logic          accept;
    logic          wr;
    logic          rd;
    logic          ready_nxt;
    logic          unused_ok;

    // Upper address bits alias, opcode is reserved for atomics.
    assign unused_ok = ^{loc_opcode, loc_addr[AW-1:OB+IW]};

    assign index  = loc_addr[OB+IW-1:OB];
    assign offset = loc_addr[OB-1:0];
    // 16 bits so len=255 with size=7 (32768 bytes) cannot overflow.
    assign nbytes = (16'(loc_len) + 16'd1) << loc_size;
    assign accept = loc_ready & (loc_read | loc_write);
    // Write wins when both are raised; the read is then dropped.
    assign wr     = accept & loc_write;
    assign rd     = accept & loc_read & ~loc_write;
    assign wdata  = loc_wrdata << {offset, 3'b000};

    // Byte enables: bytes from offset up to offset+nbytes, clipped at the word end.
    always_comb begin
        wmask = '0;
        for (int j = 0; j < NB; j++)
            wmask[j] = (j >= int'(offset)) && ((j - int'(offset)) < int'(nbytes));
    end

`ifdef UMI_MEM_STALL_EN
    localparam int CW = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    assign cnt_nxt   = (cnt == CW'(STALL_PERIOD - 1)) ? '0 : cnt + 1'b1;
    assign ready_nxt = (cnt_nxt != CW'(STALL_PERIOD - 1));

    // Free-running stall phase counter, wraps every STALL_PERIOD cycles.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end
`else
    assign ready_nxt = 1'b1;
`endif

    // Registered ready: low in reset, then follows the stall pattern (or stays high).
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            loc_ready <= 1'b0;
        else
            loc_ready <= ready_nxt;
    end

    // Memory array is not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr)
            for (int j = 0; j < NB; j++)
                if (wmask[j])
                    mem[index][8*j +: 8] <= wdata[8*j +: 8];
    end

    // Read result, shifted down so the addressed byte lands at bit 0.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            loc_rddata <= '0;
        else if (rd)
            loc_rddata <= mem[index] >> {offset, 3'b000};
    end
endmodule

// File: tb/tb_umi_mem_device.sv
// tb_umi_mem_device: directed self-checking bench for umi_mem_device (DW=256, DEPTH=16).
module tb_umi_mem_device;
    logic         clk;
    logic         nreset;
    logic [63:0]  loc_addr;
    logic         loc_write;
    logic         loc_read;
    logic [7:0]   loc_opcode;
    logic [2:0]   loc_size;
    logic [7:0]   loc_len;
    logic [255:0] loc_wrdata;
    logic [255:0] loc_rddata;
    logic         loc_ready;

    int tests = 0;
    int fails = 0;

    logic [255:0] w0_exp;
    logic [255:0] w1_exp;
    logic [255:0] pat;

    umi_mem_device #(.AW(64), .DW(256), .DEPTH(16), .STALL_PERIOD(4)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .loc_addr   (loc_addr),
        .loc_write  (loc_write),
        .loc_read   (loc_read),
        .loc_opcode (loc_opcode),
        .loc_size   (loc_size),
        .loc_len    (loc_len),
        .loc_wrdata (loc_wrdata),
        .loc_rddata (loc_rddata),
        .loc_ready  (loc_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge: waits (bounded) for ready, drives one request cycle, returns at the next negedge.
    task automatic req(input logic r, input logic w, input logic [63:0] a, input logic [2:0] s,
                       input logic [7:0] l, input logic [255:0] d);
        int n = 0;
        while (!loc_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {255'd0, loc_ready}, 256'd1);
        loc_read   = r;
        loc_write  = w;
        loc_addr   = a;
        loc_size   = s;
        loc_len    = l;
        loc_wrdata = d;
        @(negedge clk);
        loc_read  = 1'b0;
        loc_write = 1'b0;
    endtask

    task automatic wait_ready_low();
        int n = 0;
        while (loc_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("ready_low_wait", {255'd0, loc_ready}, 256'd0);
    endtask

    initial begin
        nreset     = 1'b0;
        loc_addr   = '0;
        loc_write  = 1'b0;
        loc_read   = 1'b0;
        loc_opcode = '0;
        loc_size   = '0;
        loc_len    = '0;
        loc_wrdata = '0;
        repeat (2) @(negedge clk);
        check("reset_rddata", loc_rddata, 256'd0);
        check("reset_ready", {255'd0, loc_ready}, 256'd0);
        nreset = 1'b1;
        #1 check("ready_before_edge", {255'd0, loc_ready}, 256'd0);
        @(negedge clk);
        check("ready_first_edge", {255'd0, loc_ready}, 256'd1);

        // Preload word 0 = 0, word 1 = all 0x11 with full-word writes.
        req(0, 1, 64'h00, 3'd5, 8'd0, 256'd0);
        req(0, 1, 64'h20, 3'd5, 8'd0, {32{8'h11}});

        // Word write then back-to-back read.
        req(0, 1, 64'h04, 3'd2, 8'd0, 256'hDEADBEEF);
        req(1, 0, 64'h04, 3'd0, 8'd0, 256'd0);
        check("word_lo", {224'd0, loc_rddata[31:0]}, {224'd0, 32'hDEADBEEF});
        check("word_hi_zero", {224'd0, loc_rddata[255:224]}, 256'd0);
        w0_exp = {192'd0, 32'hDEADBEEF, 32'd0};
        req(1, 0, 64'h00, 3'd0, 8'd0, 256'd0);
        check("word0_full", loc_rddata, w0_exp);

        // Single-byte write inside word 1.
        req(0, 1, 64'h23, 3'd0, 8'd0, 256'hAB);
        req(1, 0, 64'h20, 3'd0, 8'd0, 256'd0);
        w1_exp = {32{8'h11}};
        w1_exp[31:24] = 8'hAB;
        check("byte_mask", loc_rddata, w1_exp);

        // 64-byte write at offset 16 clips at the end of word 0.
        for (int i = 0; i < 32; i++) pat[8*i +: 8] = 8'(i);
        req(0, 1, 64'h10, 3'd3, 8'd7, pat);
        for (int i = 0; i < 16; i++) w0_exp[8*(16+i) +: 8] = 8'(i);
        req(1, 0, 64'h00, 3'd0, 8'd0, 256'd0);
        check("clip_word0", loc_rddata, w0_exp);
        req(1, 0, 64'h20, 3'd0, 8'd0, 256'd0);
        check("clip_word1_kept", loc_rddata, w1_exp);

        // Address 0x200 aliases onto word 0.
        req(0, 1, 64'h200, 3'd0, 8'd0, 256'h5A);
        req(1, 0, 64'h00, 3'd0, 8'd0, 256'd0);
        check("alias_byte", {248'd0, loc_rddata[7:0]}, 256'h5A);
        w0_exp[7:0] = 8'h5A;
        check("alias_word", loc_rddata, w0_exp);

        // Read at offset 28: top four bytes shifted down, rest zero.
        req(1, 0, 64'h1C, 3'd0, 8'd0, 256'd0);
        check("offset_read", loc_rddata, 256'h0F0E0D0C);

        // Read and write together: write happens, read data held.
        req(1, 1, 64'h40, 3'd2, 8'd0, 256'h12345678);
        check("rw_both_held", loc_rddata, 256'h0F0E0D0C);
        req(1, 0, 64'h40, 3'd0, 8'd0, 256'd0);
        check("rw_both_write", {224'd0, loc_rddata[31:0]}, 256'h12345678);

        // Reset right after an accepted read; a write during reset must be ignored.
        req(0, 0, 64'h0, 3'd0, 8'd0, 256'd0);
        loc_read = 1'b1;
        loc_addr = 64'h20;
        @(posedge clk);
        #1 loc_read = 1'b0;
        check("read_latency", loc_rddata, w1_exp);
        nreset = 1'b0;
        #1 check("midrst_rddata", loc_rddata, 256'd0);
        check("midrst_ready", {255'd0, loc_ready}, 256'd0);
        loc_write  = 1'b1;
        loc_addr   = 64'h20;
        loc_size   = 3'd0;
        loc_wrdata = 256'hEE;
        repeat (2) @(negedge clk);
        check("rst_ready_held", {255'd0, loc_ready}, 256'd0);
        nreset = 1'b1;
        @(negedge clk);
        loc_write = 1'b0;
        check("release_ready", {255'd0, loc_ready}, 256'd1);
        check("release_rddata", loc_rddata, 256'd0);
        req(1, 0, 64'h20, 3'd0, 8'd0, 256'd0);
        check("retained_word1", loc_rddata, w1_exp);
        req(1, 0, 64'h00, 3'd0, 8'd0, 256'd0);
        check("retained_word0", loc_rddata, w0_exp);

`ifdef UMI_MEM_STALL_EN
        // Ready pattern 1,1,1,0 after a low cycle.
        wait_ready_low();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_pattern", {255'd0, loc_ready}, (i == 3) ? 256'd0 : 256'd1);
        end
        // Read during the low cycle is ignored.
        loc_read = 1'b1;
        loc_addr = 64'h20;
        @(negedge clk);
        loc_read = 1'b0;
        check("stall_read_held", loc_rddata, w0_exp);
        // Write during the low cycle is ignored.
        wait_ready_low();
        loc_write  = 1'b1;
        loc_addr   = 64'h00;
        loc_size   = 3'd0;
        loc_wrdata = 256'h77;
        @(negedge clk);
        loc_write = 1'b0;
        req(1, 0, 64'h00, 3'd0, 8'd0, 256'd0);
        check("stall_write_ignored", loc_rddata, w0_exp);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
